// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU control codes and the
// decoded-control bundle that travels through the ID/EX register (E1).
package exec_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Decoded controls latched into E1 alongside the operands.
    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
    } e1_ctrl_t;

endpackage : exec_pkg

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage. The zero flag always reflects
// a - b, independent of ctrl, so a branch compare works with any opcode.
module exec_alu
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [XLEN-1:0] diff;

    assign diff = a - b;
    assign zero = (diff == '0);

    // Select the operation result; unknown codes yield zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves result unassigned (no latch).
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = diff;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule : exec_alu

// File: rtl/exec_stage.sv
// Execute stage: ID/EX register (E1), ALU / branch evaluation, EX/MEM
// register (E2), with valid/ready handshakes on both boundaries.
// Optional build macro EXEC_FWD_EN enables E2 -> E1 operand forwarding.
module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [XLEN-1:0]  rd1,
    input  logic [XLEN-1:0]  rd2,
    input  logic [15:0]      imm,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [RADDR-1:0] rs,
    input  logic [RADDR-1:0] rt,
    input  logic [RADDR-1:0] wreg,
    input  logic [3:0]       alu_ctrl,
    input  logic             alu_src,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_result,
    output logic [XLEN-1:0]  store_data,
    output logic [XLEN-1:0]  branch_target,
    output logic [RADDR-1:0] wreg_out,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             mem_to_reg_o,
    output logic             branch_taken
);

    // E1 state
    logic             e1_valid;
    e1_ctrl_t         e1_ctrl;
    logic [XLEN-1:0]  e1_rd1, e1_rd2, e1_pc4;
    logic [15:0]      e1_imm;
    logic [RADDR-1:0] e1_rs, e1_rt, e1_wreg;

    // Handshake
    logic e2_adv, e1_load;

    assign e2_adv   = e1_valid & (~out_valid | out_ready);
    assign in_ready = ~e1_valid | e2_adv;
    assign e1_load  = in_valid & in_ready & ~flush;

    // E1 occupancy: flush wins, then capture, then drain into E2.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (!rst_n)       e1_valid <= 1'b0;
        else if (flush)   e1_valid <= 1'b0;
        else if (e1_load) e1_valid <= 1'b1;
        else if (e2_adv)  e1_valid <= 1'b0;
    end

    // E1 payload capture.
    // NOTE: payload is not reset; it is only observed while e1_valid is set.
    always_ff @(posedge clk) begin
        if (e1_load) begin
            e1_rd1  <= rd1;
            e1_rd2  <= rd2;
            e1_pc4  <= pc_plus4;
            e1_imm  <= imm;
            e1_rs   <= rs;
            e1_rt   <= rt;
            e1_wreg <= wreg;
            e1_ctrl <= '{alu_ctrl: alu_ctrl, alu_src: alu_src, reg_write: reg_write,
                         mem_read: mem_read, mem_write: mem_write,
                         mem_to_reg: mem_to_reg, branch: branch};
        end
    end

    // Execute datapath
    logic [XLEN-1:0] imm_ext, op_a, op_rt, op_b, alu_res;
    logic            alu_zero;

    assign imm_ext = {{(XLEN-16){e1_imm[15]}}, e1_imm};

`ifdef EXEC_FWD_EN
    // A valid E2 ALU result that will be written back replaces the stale
    // register-file value; a zero destination is never forwarded.
    logic fwd_ok;
    assign fwd_ok = out_valid & reg_write_o & ~mem_read_o & (wreg_out != '0);
    assign op_a   = (fwd_ok && e1_rs == wreg_out) ? alu_result : e1_rd1;
    assign op_rt  = (fwd_ok && e1_rt == wreg_out) ? alu_result : e1_rd2;
`else
    logic unused_src;
    assign unused_src = ^{e1_rs, e1_rt};
    assign op_a       = e1_rd1;
    assign op_rt      = e1_rd2;
`endif

    assign op_b = e1_ctrl.alu_src ? imm_ext : op_rt;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .ctrl   (e1_ctrl.alu_ctrl),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // E2 register: load on advance, otherwise drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_result    <= '0;
            store_data    <= '0;
            branch_target <= '0;
            wreg_out      <= '0;
            reg_write_o   <= 1'b0;
            mem_read_o    <= 1'b0;
            mem_write_o   <= 1'b0;
            mem_to_reg_o  <= 1'b0;
            branch_taken  <= 1'b0;
        end else if (e2_adv) begin
            out_valid     <= 1'b1;
            alu_result    <= alu_res;
            store_data    <= op_rt;
            branch_target <= e1_pc4 + (imm_ext << 2);
            wreg_out      <= e1_wreg;
            reg_write_o   <= e1_ctrl.reg_write;
            mem_read_o    <= e1_ctrl.mem_read;
            mem_write_o   <= e1_ctrl.mem_write;
            mem_to_reg_o  <= e1_ctrl.mem_to_reg;
            branch_taken  <= e1_ctrl.branch & alu_zero;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule : exec_stage

// File: tb/tb_exec_stage.sv
// Directed testbench for exec_stage. Expected values are hand-computed
// constants plus a small occupancy/order model for the back-pressure run.
module tb_exec_stage;
    import exec_pkg::*;

`ifdef EXEC_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0;
    logic [31:0] rd1, rd2, pc_plus4;
    logic [15:0] imm;
    logic [4:0]  rs, rt, wreg;
    logic [3:0]  alu_ctrl;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] alu_result, store_data, branch_target;
    logic [4:0]  wreg_out;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exec_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc_plus4(pc_plus4), .rs(rs), .rt(rt), .wreg(wreg),
        .alu_ctrl(alu_ctrl), .alu_src(alu_src), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .store_data(store_data), .branch_target(branch_target), .wreg_out(wreg_out),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_to_reg_o(mem_to_reg_o), .branch_taken(branch_taken)
    );

    // Present one decoded instruction on the inputs (mem_to_reg follows mem_read).
    task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                       input logic [31:0] pc, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] w, input logic [3:0] c, input logic src,
                       input logic rw, input logic mr, input logic mw, input logic br);
        rd1 = a; rd2 = b; imm = im; pc_plus4 = pc; rs = s; rt = t; wreg = w;
        alu_ctrl = c; alu_src = src; reg_write = rw; mem_read = mr; mem_write = mw;
        mem_to_reg = mr; branch = br;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step(); step();
    endtask

    task automatic test_reset();
        put(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (alu_result !== 32'h0) begin n_bad++; $display("FAIL reset_alu_result: got %h want 0", alu_result); end
        @(negedge clk); rst_n = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_add();
        drain();
        put(32'h7FFF_FFFF, 32'h1, 0, 0, 5'd1, 5'd2, 5'd3, ALU_ADD, 0, 1, 0, 0, 0);
        in_valid = 1'b1; step(); in_valid = 1'b0; step();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
        n_cmp++; if (alu_result !== 32'h8000_0000) begin n_bad++; $display("FAIL add_result: got %h want 80000000", alu_result); end
        n_cmp++; if (wreg_out !== 5'd3) begin n_bad++; $display("FAIL add_wreg: got %0d want 3", wreg_out); end
        n_cmp++; if (reg_write_o !== 1'b1 || branch_taken !== 1'b0) begin n_bad++; $display("FAIL add_ctrl: got rw=%b bt=%b want rw=1 bt=0", reg_write_o, branch_taken); end
        n_cmp++; if (store_data !== 32'h1) begin n_bad++; $display("FAIL add_store: got %h want 1", store_data); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_consumed: got %b want 0", out_valid); end
    endtask

    task automatic test_slt_imm();
        drain();
        put(32'hFFFF_FFFF, 32'h0, 16'h0001, 0, 1, 2, 6, ALU_SLT, 1, 1, 0, 0, 0);
        in_valid = 1'b1; step();
        put(32'hFFFF_FFFF, 32'h0, 16'h0001, 0, 1, 2, 6, 4'b1111, 1, 1, 0, 0, 0);
        step(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'h1) begin n_bad++; $display("FAIL slt_result: got v=%b %h want v=1 1", out_valid, alu_result); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'h0) begin n_bad++; $display("FAIL bad_code_result: got v=%b %h want v=1 0", out_valid, alu_result); end
    endtask

    task automatic test_branch();
        drain();
        put(5, 5, 16'hFFFF, 32'h100, 1, 2, 0, ALU_SUB, 0, 0, 0, 0, 1);
        in_valid = 1'b1; step();
        put(5, 6, 16'h0004, 32'h100, 1, 2, 0, ALU_SUB, 0, 0, 0, 0, 1);
        step();
        n_cmp++; if (branch_taken !== 1'b1 || branch_target !== 32'hFC) begin n_bad++; $display("FAIL beq_taken: got bt=%b tgt=%h want bt=1 tgt=fc", branch_taken, branch_target); end
        put(0, 0, 16'h0002, 32'hFFFF_FFFC, 1, 2, 0, ALU_SUB, 0, 0, 0, 0, 1);
        step(); in_valid = 1'b0;
        n_cmp++; if (branch_taken !== 1'b0 || branch_target !== 32'h110 || alu_result !== 32'hFFFF_FFFF)
            begin n_bad++; $display("FAIL beq_not_taken: got bt=%b tgt=%h res=%h want bt=0 tgt=110 res=ffffffff", branch_taken, branch_target, alu_result); end
        step();
        n_cmp++; if (branch_taken !== 1'b1 || branch_target !== 32'h4) begin n_bad++; $display("FAIL target_wrap: got bt=%b tgt=%h want bt=1 tgt=4", branch_taken, branch_target); end
    endtask

    task automatic test_back_pressure();
        logic [31:0] exp_q[$];
        logic        m_e1, m_e2, exp_ir, fire_in, fire_out, adv, stall_prev, saw_block;
        logic [31:0] snap;
        int          sent, recv;
        drain();
        m_e1 = 0; m_e2 = 0; stall_prev = 0; saw_block = 0; sent = 0; recv = 0; snap = 0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            if (sent < 6) begin
                put(32'(100 + sent), 0, 0, 0, 1, 2, 5'(sent + 1), ALU_ADD, 0, 1, 0, 0, 0);
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            @(negedge clk);
            exp_ir = !m_e1 || !m_e2 || out_ready;
            if (!exp_ir) saw_block = 1;
            n_cmp++; if (in_ready !== exp_ir) begin n_bad++; $display("FAIL bp_in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_ir); end
            n_cmp++; if (out_valid !== m_e2) begin n_bad++; $display("FAIL bp_out_valid cyc%0d: got %b want %b", cyc, out_valid, m_e2); end
            if (stall_prev) begin
                n_cmp++; if (alu_result !== snap) begin n_bad++; $display("FAIL bp_hold cyc%0d: got %h want %h", cyc, alu_result, snap); end
            end
            stall_prev = out_valid & ~out_ready;
            snap       = alu_result;
            fire_in    = in_valid & in_ready;
            fire_out   = out_valid & out_ready;
            if (fire_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra_out: got %h want none", alu_result); end
                else begin
                    if (alu_result !== exp_q[0]) begin n_bad++; $display("FAIL bp_order: got %h want %h", alu_result, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                recv++;
            end
            adv = m_e1 & (~m_e2 | out_ready);
            if (fire_in) begin exp_q.push_back(32'(100 + sent)); sent++; end
            m_e2 = adv ? 1'b1 : (out_ready ? 1'b0 : m_e2);
            m_e1 = fire_in ? 1'b1 : (adv ? 1'b0 : m_e1);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (recv != 6 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_count: got %0d left %0d want 6 left 0", recv, exp_q.size()); end
        n_cmp++; if (saw_block !== 1'b1) begin n_bad++; $display("FAIL bp_blocked: got %b want 1", saw_block); end
    endtask

    task automatic test_flush();
        drain();
        // Flush while E2 is stalled: the E1 instruction is squashed.
        out_ready = 1'b0;
        put(32'h11, 0, 0, 0, 1, 2, 1, ALU_ADD, 0, 1, 0, 0, 0);
        in_valid = 1'b1; step();
        put(32'h22, 0, 0, 0, 1, 2, 2, ALU_ADD, 0, 1, 0, 0, 0);
        step(); in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_full_ready: got %b want 0", in_ready); end
        flush = 1'b1; step(); flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'h11 || in_ready !== 1'b1)
            begin n_bad++; $display("FAIL flush_e2_kept: got v=%b %h ir=%b want v=1 11 ir=1", out_valid, alu_result, in_ready); end
        out_ready = 1'b1; step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_squash: got v=%b %h want v=0", out_valid, alu_result); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_squash_late: got v=%b %h want v=0", out_valid, alu_result); end
        // Flush together with an advance: old E1 moves on, new input dropped.
        put(32'h33, 0, 0, 0, 1, 2, 3, ALU_ADD, 0, 1, 0, 0, 0);
        in_valid = 1'b1; step();
        put(32'h44, 0, 0, 0, 1, 2, 4, ALU_ADD, 0, 1, 0, 0, 0);
        flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'h33) begin n_bad++; $display("FAIL flush_adv_old: got v=%b %h want v=1 33", out_valid, alu_result); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_adv_drop: got v=%b ir=%b want v=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_reset_midstream();
        drain();
        out_ready = 1'b0;
        put(5, 5, 16'h0010, 32'h200, 1, 2, 7, ALU_ADD, 0, 1, 1, 1, 1);
        in_valid = 1'b1; step();
        put(9, 9, 0, 0, 1, 2, 8, ALU_ADD, 0, 1, 0, 0, 0);
        step(); in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd10 || branch_target !== 32'h240 || branch_taken !== 1'b1)
            begin n_bad++; $display("FAIL rst_pre: got v=%b %h tgt=%h bt=%b want v=1 a 240 1", out_valid, alu_result, branch_target, branch_taken); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || alu_result !== 32'h0 || store_data !== 32'h0 || branch_target !== 32'h0)
            begin n_bad++; $display("FAIL rst_async_data: got v=%b %h %h %h want all 0", out_valid, alu_result, store_data, branch_target); end
        n_cmp++; if ({wreg_out, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken} !== 10'h0)
            begin n_bad++; $display("FAIL rst_async_ctrl: got %b want 0", {wreg_out, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken}); end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release: got ir=%b v=%b want ir=1 v=0", in_ready, out_valid); end
    endtask

    task automatic test_forward();
        logic [31:0] exp;
        drain();
        // r4 = 10, then r5 = r4 + 1 with a stale rd1.
        put(10, 0, 0, 0, 1, 2, 4, ALU_ADD, 0, 1, 0, 0, 0); in_valid = 1'b1; step();
        put(0, 0, 16'h1, 0, 4, 2, 5, ALU_ADD, 1, 1, 0, 0, 0); step(); in_valid = 1'b0; step();
        exp = FWD ? 32'd11 : 32'd1;
        n_cmp++; if (alu_result !== exp) begin n_bad++; $display("FAIL fwd_rs: got %0d want %0d", alu_result, exp); end
        // Forward through rt into the B operand and store data.
        put(10, 0, 0, 0, 1, 2, 4, ALU_ADD, 0, 1, 0, 0, 0); in_valid = 1'b1; step();
        put(1, 7, 0, 0, 3, 4, 6, ALU_ADD, 0, 0, 0, 1, 0); step(); in_valid = 1'b0; step();
        exp = FWD ? 32'd11 : 32'd8;
        n_cmp++; if (alu_result !== exp) begin n_bad++; $display("FAIL fwd_rt: got %0d want %0d", alu_result, exp); end
        exp = FWD ? 32'd10 : 32'd7;
        n_cmp++; if (store_data !== exp) begin n_bad++; $display("FAIL fwd_store: got %0d want %0d", store_data, exp); end
        // Destination r0 is never forwarded.
        put(10, 0, 0, 0, 1, 2, 0, ALU_ADD, 0, 1, 0, 0, 0); in_valid = 1'b1; step();
        put(0, 0, 16'h1, 0, 0, 2, 5, ALU_ADD, 1, 1, 0, 0, 0); step(); in_valid = 1'b0; step();
        n_cmp++; if (alu_result !== 32'd1) begin n_bad++; $display("FAIL fwd_r0: got %0d want 1", alu_result); end
        // A load in E2 is not forwarded.
        put(10, 0, 0, 0, 1, 2, 4, ALU_ADD, 0, 1, 1, 0, 0); in_valid = 1'b1; step();
        put(0, 0, 16'h1, 0, 4, 2, 5, ALU_ADD, 1, 1, 0, 0, 0); step(); in_valid = 1'b0; step();
        n_cmp++; if (alu_result !== 32'd1) begin n_bad++; $display("FAIL fwd_load: got %0d want 1", alu_result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_slt_imm();
        test_branch();
        test_back_pressure();
        test_flush();
        test_reset_midstream();
        test_forward();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_exec_stage

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage placed directly downstream of the decode/register-read block.
- Latches decoded operands and control into an ID/EX register (E1) and evaluates the ALU, branch compare and branch target.
- Registers results into an EX/MEM register (E2) that feeds the memory stage.
- Both register boundaries use valid/ready handshakes, so it supports stall, flush and back-pressure.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  E1 can accept.
- flush  in  1  squash E1 contents (branch mispredict).
- rd1, rd2  in  XLEN  register operands.
- imm  in  16  raw immediate.
- pc_plus4  in  XLEN  PC+4 of the instruction.
- rs, rt, wreg  in  RADDR  source and destination addresses.
- alu_ctrl  in  4  ALU control code.
- alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch  in  1 each  decoded controls.
- out_valid  out  1  E2 holds a result.
- out_ready  in  1  memory stage accepts.
- alu_result, store_data, branch_target  out  XLEN  E2 fields.
- wreg_out  out  RADDR  E2 destination.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_taken  out  1 each  E2 controls.

Behaviour:
- Reset (async, rst_n=0):
  - E1 and E2 valid bits are 0.
  - All E2 outputs are 0.
  - out_valid=0; in_ready=1 once reset is released.
- Handshakes:
  - e2_adv = e1_valid & (~out_valid | out_ready).
  - in_ready = ~e1_valid | e2_adv. This is combinational, with no dependence on in_valid.
  - E1 captures all inputs when in_valid & in_ready & ~flush.
  - E2 captures the E1 results when e2_adv.
  - out_valid clears when out_ready & ~e2_adv.
- Latency:
  - 2 cycles input-to-output with no back-pressure.
  - Throughput is one instruction per cycle.
- Flush:
  - Clears e1_valid at the next edge, whether or not e1 would advance.
  - Suppresses capture in that cycle.
  - E2 is unaffected.
- Operand selection:
  - opB = alu_src ? sign_extend(imm) : rd2.
  - store_data = rd2, forwarded if applicable.
- ALU codes:
  - 0010 ADD, modulo 2^XLEN, no overflow trap.
  - 0110 SUB.
  - 0000 AND.
  - 0001 OR.
  - 0111 SLT: signed compare, result 1 or 0.
  - Any other code gives result 0.
- Branch:
  - zero = (A - opB == 0).
  - branch_taken = branch & zero, registered into E2.
  - branch_target = pc_plus4 + (sign_extend(imm) << 2), wrapping modulo 2^XLEN.
- Store hold:
  - While out_valid & ~out_ready, all E2 outputs hold stable.
  - E1 also holds, and in_ready=0.
- Simultaneous events:
  - An E1 capture and an E2 advance in the same cycle are legal: the pipeline moves forward.
  - flush together with e2_adv: E1's old instruction still moves into E2 (it is older than the branch resolving it), and the new input is dropped.

Optional Feature:
- Macro EXEC_FWD_EN.
- Defined:
  - When E2 is valid, reg_write_o=1, mem_read_o=0 and wreg_out!=0, an E1 operand whose rs (or rt) equals wreg_out uses E2 alu_result instead of rd1 (or rd2).
  - This applies to the ALU A input, the B input (when alu_src=0) and store_data.
  - rs or rt equal to 0 is never forwarded.
- Undefined: operands come straight from the E1 latch.

Decomposition:
- Package exec_pkg holds:
  - localparams ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_SLT=4'b0111.
  - A packed struct for the E1 control bundle.
- One combinational sub-module, exec_alu (a, b, ctrl -> result, zero), is natural.
- Pipeline registers and handshakes stay in exec_stage.

Test Plan:
- Reset mid-stream: assert rst_n=0 with E1 and E2 both valid -> out_valid=0 and all outputs 0 immediately, asynchronously; in_ready=1 after release.
- ADD: rd1=0x7FFFFFFF, rd2=1, alu_ctrl=0010, wreg=3 -> two cycles later out_valid=1, alu_result=0x80000000, wreg_out=3.
- SLT and immediate: rd1=0xFFFFFFFF, imm=0x0001, alu_src=1, alu_ctrl=0111 -> alu_result=1; alu_ctrl=1111 -> alu_result=0.
- BEQ: rd1=rd2=5, branch=1, alu_ctrl=0110, pc_plus4=0x100, imm=0xFFFF -> branch_taken=1, branch_target=0xFC.
- Back-pressure and flush:
  - Hold out_ready=0 for 3 cycles with a stream of inputs -> E2 outputs stable, in_ready=0 after E1 fills, no instruction lost or duplicated.
  - Assert flush with E1 valid -> that instruction never appears at the output.
- EXEC_FWD_EN:
  - Instruction A: ADD writes r4=10.
  - Instruction B: r5 = r4 + 1 back-to-back, with stale rd1=0.
  - Expect 11 with the macro defined, 1 without.
  - With wreg=0 the result is never forwarded.
